boid_position_unit: RTL

- Holds position and velocity state for NUM_BOIDS boids.
- On each frame_start pulse, walks every boid in index order. For each boid it advances the position by one velocity step, applies edge bounce or wrap, and emits the boid's framebuffer pixel address.
- Emission uses a valid/ready handshake to the framebuffer writer.
- Sits between the frame timing logic (frame_start) and the framebuffer write port. Successor to the single-boid free-running locator.

---
 rtl/boid_pkg.sv | 19 +
 rtl/boid_position_unit_if.sv | 28 ++
 rtl/boid_axis_step.sv | 49 ++++
 rtl/boid_position_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/boid_pkg.sv
// rtl/boid_pkg.sv - shared screen geometry, coordinate widths and FSM encoding for the boid datapath
// Contents: screen size and pixel count, framebuffer address width,
//           x/y coordinate widths, position-unit state encoding.
package boid_pkg;

    localparam int VIDEO_WIDTH         = 640;
    localparam int VIDEO_HEIGHT        = 480;
    localparam int PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
    localparam int PIXEL_ADDRESS_WIDTH = $clog2(PIXEL_COUNT) + 1;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/boid_position_unit_if.sv
// rtl/boid_position_unit_if.sv - pixel handshake bundle from the position unit to the framebuffer writer
// Signals: pix_valid/pix_ready handshake, pix_addr framebuffer address,
//          pix_x/pix_y updated coordinates, pix_id boid index.
// master = position unit, slave = framebuffer writer.
interface boid_position_unit_if #(
    parameter int IDX_W = 3,
    parameter int PA_W  = boid_pkg::PIXEL_ADDRESS_WIDTH
);
    import boid_pkg::*;

    logic             pix_valid;
    logic             pix_ready;
    logic [PA_W-1:0]  pix_addr;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic [IDX_W-1:0] pix_id;

    modport master (
        output pix_valid, pix_addr, pix_x, pix_y, pix_id,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_addr, pix_x, pix_y, pix_id,
        output pix_ready
    );

endinterface

// File: rtl/boid_axis_step.sv
// rtl/boid_axis_step.sv - one-axis position step with reflect or toroidal wrap at the screen edges
// Ports: pos/vel current state, limit = last legal coordinate, wrap_mode (0 reflect, 1 wrap),
//        new_pos/new_vel next state. Purely combinational.
module boid_axis_step #(
    parameter int W  = 10,
    parameter int VW = 4
) (
    input  logic [W-1:0]          pos,
    input  logic signed [VW-1:0]  vel,
    input  logic [W-1:0]          limit,
    input  logic                  wrap_mode,
    output logic [W-1:0]          new_pos,
    output logic signed [VW-1:0]  new_vel
);

    // One bit wider than the coordinate so both under- and overshoot stay representable.
    logic signed [W:0] n;
    logic signed [W:0] lim;
    logic signed [W:0] span;
    logic signed [W:0] r;

    assign n    = $signed({1'b0, pos}) + $signed({{(W+1-VW){vel[VW-1]}}, vel});
    assign lim  = $signed({1'b0, limit});
    assign span = lim + $signed((W+1)'(1));

    always_comb begin
        r       = n;
        new_vel = vel;
        if (n[W]) begin
            if (wrap_mode) begin
                r = n + span;
            end else begin
                r       = -n;
                new_vel = -vel;
            end
        end else if (n > lim) begin
            if (wrap_mode) begin
                r = n - span;
            end else begin
                // 2L - n written as L - (n - L) so 2L never has to fit in W+1 bits.
                r       = lim - (n - lim);
                new_vel = -vel;
            end
        end
    end

    assign new_pos = W'(r);

endmodule

// File: rtl/boid_position_unit.sv
// rtl/boid_position_unit.sv - multi-boid position/velocity store that emits one pixel per boid per frame
// Ports: clock, resetn (sync, active low), frame_start pass request,
//        load_en/load_idx/load_x/load_y/load_dx/load_dy boid write (IDLE only),
//        pix (master) pixel handshake to the framebuffer writer,
//        busy (not IDLE), frame_done (one-cycle end-of-pass pulse).
module boid_position_unit #(
    parameter int NUM_BOIDS    = 8,
    parameter int VIDEO_WIDTH  = boid_pkg::VIDEO_WIDTH,
    parameter int VIDEO_HEIGHT = boid_pkg::VIDEO_HEIGHT,
    parameter int VEL_WIDTH    = 4,
    parameter int WRAP_MODE    = 0,
    localparam int IDX_W       = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        frame_start,
    input  logic                        load_en,
    input  logic [IDX_W-1:0]            load_idx,
    input  logic [9:0]                  load_x,
    input  logic [8:0]                  load_y,
    input  logic signed [VEL_WIDTH-1:0] load_dx,
    input  logic signed [VEL_WIDTH-1:0] load_dy,
    boid_position_unit_if.master        pix,
    output logic                        busy,
    output logic                        frame_done
);
    import boid_pkg::*;

    localparam int PA_W = PIXEL_ADDRESS_WIDTH;
    localparam logic [X_W-1:0] X_LIM = X_W'(VIDEO_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(VIDEO_HEIGHT - 1);
    localparam logic signed [VEL_WIDTH-1:0] V_ONE = {{(VEL_WIDTH-1){1'b0}}, 1'b1};

    logic [X_W-1:0]              x_q  [NUM_BOIDS];
    logic [Y_W-1:0]              y_q  [NUM_BOIDS];
    logic signed [VEL_WIDTH-1:0] dx_q [NUM_BOIDS];
    logic signed [VEL_WIDTH-1:0] dy_q [NUM_BOIDS];

    logic [1:0]                  state;
    logic [IDX_W-1:0]            idx;

    logic [X_W-1:0]              nx;
    logic [Y_W-1:0]              ny;
    logic signed [VEL_WIDTH-1:0] nvx;
    logic signed [VEL_WIDTH-1:0] nvy;
    logic [PA_W-1:0]             addr;

    boid_axis_step #(.W(X_W), .VW(VEL_WIDTH)) u_step_x (
        .pos       (x_q[idx]),
        .vel       (dx_q[idx]),
        .limit     (X_LIM),
        .wrap_mode (WRAP_MODE != 0),
        .new_pos   (nx),
        .new_vel   (nvx)
    );

    boid_axis_step #(.W(Y_W), .VW(VEL_WIDTH)) u_step_y (
        .pos       (y_q[idx]),
        .vel       (dy_q[idx]),
        .limit     (Y_LIM),
        .wrap_mode (WRAP_MODE != 0),
        .new_pos   (ny),
        .new_vel   (nvy)
    );

    // 640*y = 512*y + 128*y; other widths fall back to a plain multiply.
    generate
        if (VIDEO_WIDTH == 640) begin : g_addr_shift_add
            assign addr = (PA_W'(ny) << 9) + (PA_W'(ny) << 7) + PA_W'(nx);
        end else begin : g_addr_mul
            assign addr = PA_W'(ny) * PA_W'(VIDEO_WIDTH) + PA_W'(nx);
        end
    endgenerate

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            idx           <= '0;
            frame_done    <= 1'b0;
            pix.pix_valid <= 1'b0;
            pix.pix_addr  <= '0;
            pix.pix_x     <= '0;
            pix.pix_y     <= '0;
            pix.pix_id    <= '0;
            for (int i = 0; i < NUM_BOIDS; i++) begin
                x_q[i]  <= X_W'((10 + 32 * i) % VIDEO_WIDTH);
                y_q[i]  <= Y_W'(10);
                dx_q[i] <= V_ONE;
                dy_q[i] <= V_ONE;
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A load wins over a simultaneous frame_start, which is then lost.
                    if (load_en) begin
                        x_q[load_idx]  <= (load_x > X_LIM) ? X_LIM : load_x;
                        y_q[load_idx]  <= (load_y > Y_LIM) ? Y_LIM : load_y;
                        dx_q[load_idx] <= load_dx;
                        dy_q[load_idx] <= load_dy;
                    end else if (frame_start) begin
                        idx   <= '0;
                        state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    x_q[idx]      <= nx;
                    y_q[idx]      <= ny;
                    dx_q[idx]     <= nvx;
                    dy_q[idx]     <= nvy;
                    pix.pix_x     <= nx;
                    pix.pix_y     <= ny;
                    pix.pix_id    <= idx;
                    pix.pix_addr  <= addr;
                    pix.pix_valid <= 1'b1;
                    state         <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (pix.pix_ready) begin
                        pix.pix_valid <= 1'b0;
                        if (idx == IDX_W'(NUM_BOIDS - 1)) begin
                            frame_done <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_UPDATE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
